// File: rtl/control_unit.sv
// RV32I execute-stage control unit: combinational decode of branch/jump,
// memory strobes, store data and writeback, all registered once per clock.
module control_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rs1_input,
    input  logic [31:0] rs2_input,
    input  logic [31:0] rd_input,
    input  logic [31:0] imm,
    input  logic [2:0]  func3,
    input  logic [6:0]  func7,
    input  logic        rd_valid,
    input  logic        rs1_valid,
    input  logic        rs2_valid,
    input  logic        imm_valid,
    input  logic [31:0] mem_read,
    input  logic [46:0] out_signal,
    input  logic [6:0]  opcode,
    input  logic [31:0] decoder_signal,
    input  logic [31:0] pc_input,
    output logic [46:0] instructions,
    output logic [31:0] pc_output,
    output logic        rs1_output,
    output logic        rs2_output,
    output logic [31:0] mem_write,
    output logic        wr_en,
    output logic        rd_en,
    output logic        addr,
    output logic        j_signal,
    output logic [31:0] jump,
    output logic [31:0] final_output
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [46:0] instructions_d, instructions_q;
    logic [31:0] pc_output_d, pc_output_q;
    logic        rs1_output_d, rs1_output_q;
    logic        rs2_output_d, rs2_output_q;
    logic [31:0] mem_write_d, mem_write_q;
    logic        wr_en_d, wr_en_q;
    logic        rd_en_d, rd_en_q;
    logic        addr_d, addr_q;
    logic        j_signal_d, j_signal_q;
    logic [31:0] jump_d, jump_q;
    logic [31:0] final_output_d, final_output_q;

    logic [31:0] rs1e, rs2e, imme, pc_plus4;
    logic        opc_known, legal, taken;
    logic        is_lui, is_auipc, is_jal, is_jalr, is_branch;
    logic        is_load, is_store, is_opimm, is_op;

    always_comb begin
        rs1e     = rs1_valid ? rs1_input : '0;
        rs2e     = rs2_valid ? rs2_input : '0;
        imme     = imm_valid ? imm : '0;
        pc_plus4 = pc_input + 32'd4;

        opc_known = (opcode == OPC_LUI)    || (opcode == OPC_AUIPC) ||
                    (opcode == OPC_JAL)    || (opcode == OPC_JALR)  ||
                    (opcode == OPC_BRANCH) || (opcode == OPC_LOAD)  ||
                    (opcode == OPC_STORE)  || (opcode == OPC_OPIMM) ||
                    (opcode == OPC_OP);
        legal = (decoder_signal[6:0] == opcode) && opc_known &&
                ((opcode != OPC_OP) || (func7 == 7'b0000000) || (func7 == 7'b0100000));

        is_lui    = legal && (opcode == OPC_LUI);
        is_auipc  = legal && (opcode == OPC_AUIPC);
        is_jal    = legal && (opcode == OPC_JAL);
        is_jalr   = legal && (opcode == OPC_JALR);
        is_branch = legal && (opcode == OPC_BRANCH);
        is_load   = legal && (opcode == OPC_LOAD);
        is_store  = legal && (opcode == OPC_STORE);
        is_opimm  = legal && (opcode == OPC_OPIMM);
        is_op     = legal && (opcode == OPC_OP);

        case (func3)
            3'b000:  taken = (rs1e == rs2e);
            3'b001:  taken = (rs1e != rs2e);
            3'b100:  taken = ($signed(rs1e) <  $signed(rs2e));
            3'b101:  taken = ($signed(rs1e) >= $signed(rs2e));
            3'b110:  taken = (rs1e <  rs2e);
            3'b111:  taken = (rs1e >= rs2e);
            default: taken = 1'b0;
        endcase

        instructions_d = legal ? out_signal : '0;
        rs1_output_d   = rs1_valid;
        rs2_output_d   = rs2_valid;
        j_signal_d     = is_jal || is_jalr || (is_branch && taken);

        jump_d = '0;
        if (is_jal || is_branch)
            jump_d = pc_input + imme;
        else if (is_jalr)
            jump_d = (rs1e + imme) & ~32'd1;

        pc_output_d = j_signal_d ? jump_d : pc_plus4;

        rd_en_d     = is_load;
        wr_en_d     = 1'b0;
        mem_write_d = '0;
        if (is_store) begin
            wr_en_d = 1'b1;
            case (func3)
                3'b000:  mem_write_d = {24'd0, rs2e[7:0]};
                3'b001:  mem_write_d = {16'd0, rs2e[15:0]};
                3'b010:  mem_write_d = rs2e;
                default: wr_en_d = 1'b0;
            endcase
        end
        addr_d = wr_en_d || rd_en_d;

        final_output_d = '0;
        if (rd_valid) begin
            if (is_load) begin
                case (func3)
                    3'b000:  final_output_d = {{24{mem_read[7]}}, mem_read[7:0]};
                    3'b001:  final_output_d = {{16{mem_read[15]}}, mem_read[15:0]};
                    3'b010:  final_output_d = mem_read;
                    3'b100:  final_output_d = {24'd0, mem_read[7:0]};
                    3'b101:  final_output_d = {16'd0, mem_read[15:0]};
                    default: final_output_d = '0;
                endcase
            end else if (is_lui) begin
                final_output_d = imme;
            end else if (is_auipc) begin
                final_output_d = pc_input + imme;
            end else if (is_jal || is_jalr) begin
                final_output_d = pc_plus4;
            end else if (is_op || is_opimm) begin
                final_output_d = rd_input;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instructions_q <= '0;
            pc_output_q    <= '0;
            rs1_output_q   <= 1'b0;
            rs2_output_q   <= 1'b0;
            mem_write_q    <= '0;
            wr_en_q        <= 1'b0;
            rd_en_q        <= 1'b0;
            addr_q         <= 1'b0;
            j_signal_q     <= 1'b0;
            jump_q         <= '0;
            final_output_q <= '0;
        end else begin
            instructions_q <= instructions_d;
            pc_output_q    <= pc_output_d;
            rs1_output_q   <= rs1_output_d;
            rs2_output_q   <= rs2_output_d;
            mem_write_q    <= mem_write_d;
            wr_en_q        <= wr_en_d;
            rd_en_q        <= rd_en_d;
            addr_q         <= addr_d;
            j_signal_q     <= j_signal_d;
            jump_q         <= jump_d;
            final_output_q <= final_output_d;
        end
    end

    assign instructions = instructions_q;
    assign pc_output    = pc_output_q;
    assign rs1_output   = rs1_output_q;
    assign rs2_output   = rs2_output_q;
    assign mem_write    = mem_write_q;
    assign wr_en        = wr_en_q;
    assign rd_en        = rd_en_q;
    assign addr         = addr_q;
    assign j_signal     = j_signal_q;
    assign jump         = jump_q;
    assign final_output = final_output_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: expected outputs are queued when each
// instruction is driven and compared one cycle later.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rs1_input, rs2_input, rd_input, imm;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        rd_valid, rs1_valid, rs2_valid, imm_valid;
    logic [31:0] mem_read;
    logic [46:0] out_signal;
    logic [6:0]  opcode;
    logic [31:0] decoder_signal, pc_input;
    logic [46:0] instructions;
    logic [31:0] pc_output, mem_write, jump, final_output;
    logic        rs1_output, rs2_output, wr_en, rd_en, addr, j_signal;

    typedef struct {
        logic [46:0] instr;
        logic [31:0] pc;
        logic        rs1o;
        logic        rs2o;
        logic [31:0] memw;
        logic        wr;
        logic        rd;
        logic        ad;
        logic        j;
        logic [31:0] jmp;
        logic [31:0] fin;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    exp_t zero_e = '{default: '0};
    int   checks = 0;
    int   errors = 0;

    control_unit dut (
        .clk(clk), .rst(rst),
        .rs1_input(rs1_input), .rs2_input(rs2_input), .rd_input(rd_input), .imm(imm),
        .func3(func3), .func7(func7),
        .rd_valid(rd_valid), .rs1_valid(rs1_valid), .rs2_valid(rs2_valid), .imm_valid(imm_valid),
        .mem_read(mem_read), .out_signal(out_signal), .opcode(opcode),
        .decoder_signal(decoder_signal), .pc_input(pc_input),
        .instructions(instructions), .pc_output(pc_output),
        .rs1_output(rs1_output), .rs2_output(rs2_output),
        .mem_write(mem_write), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .j_signal(j_signal), .jump(jump), .final_output(final_output)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string name, input logic [46:0] obs, input logic [46:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, name, obs, expv);
        end
    endtask

    task automatic check_all(input string tag, input exp_t x);
        chk(tag, "instructions", instructions, x.instr);
        chk(tag, "pc_output", {15'd0, pc_output}, {15'd0, x.pc});
        chk(tag, "rs1_output", {46'd0, rs1_output}, {46'd0, x.rs1o});
        chk(tag, "rs2_output", {46'd0, rs2_output}, {46'd0, x.rs2o});
        chk(tag, "mem_write", {15'd0, mem_write}, {15'd0, x.memw});
        chk(tag, "wr_en", {46'd0, wr_en}, {46'd0, x.wr});
        chk(tag, "rd_en", {46'd0, rd_en}, {46'd0, x.rd});
        chk(tag, "addr", {46'd0, addr}, {46'd0, x.ad});
        chk(tag, "j_signal", {46'd0, j_signal}, {46'd0, x.j});
        chk(tag, "jump", {15'd0, jump}, {15'd0, x.jmp});
        chk(tag, "final_output", {15'd0, final_output}, {15'd0, x.fin});
    endtask

    // Drives an instruction whose low decoder bits match opcode; callers may
    // override decoder_signal afterwards for illegal-instruction cases.
    task automatic set_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] pc, input int bit_idx);
        opcode = opc;
        decoder_signal = {25'h0, opc};
        func3 = f3;
        func7 = 7'd0;
        pc_input = pc;
        out_signal = 47'd1 << bit_idx;
        rs1_input = '0; rs2_input = '0; rd_input = '0; imm = '0; mem_read = '0;
        rd_valid = 1'b0; rs1_valid = 1'b0; rs2_valid = 1'b0; imm_valid = 1'b0;
        e = '{default: '0};
        e.instr = out_signal;
        e.pc = pc + 32'd4;
    endtask

    task automatic step(input string tag);
        exp_t x;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s.queue observed=empty expected=entry", tag);
        end else begin
            x = exp_q.pop_front();
            check_all(tag, x);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_instr(7'b0110011, 3'b000, 32'h0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", zero_e);
        rst = 1'b0;

        // OP: writeback from ALU result
        set_instr(7'b0110011, 3'b000, 32'h100, 5);
        rd_input = 32'h55; rd_valid = 1; rs1_valid = 1; rs2_valid = 1;
        e.rs1o = 1; e.rs2o = 1; e.fin = 32'h55;
        step("op_add");

        // Asynchronous reset mid-cycle clears outputs without a clock edge
        #2 rst = 1'b1;
        #1 check_all("async_rst", zero_e);
        #1 rst = 1'b0;
        step("op_after_rst");

        set_instr(7'b1100011, 3'b000, 32'h200, 10);
        rs1_input = 7; rs2_input = 7; imm = 32'h20;
        rs1_valid = 1; rs2_valid = 1; imm_valid = 1;
        e.rs1o = 1; e.rs2o = 1; e.j = 1; e.jmp = 32'h220; e.pc = 32'h220;
        step("beq_taken");

        rs2_input = 8;
        e.j = 0; e.pc = 32'h204;
        step("beq_not_taken");

        func3 = 3'b001;
        e.j = 1; e.pc = 32'h220;
        step("bne_taken");

        set_instr(7'b1100011, 3'b100, 32'h300, 11);
        rs1_input = 32'hFFFFFFFF; rs2_input = 1; imm = 32'h10;
        rs1_valid = 1; rs2_valid = 1; imm_valid = 1;
        e.rs1o = 1; e.rs2o = 1; e.jmp = 32'h310; e.j = 1; e.pc = 32'h310;
        step("blt_taken");

        func3 = 3'b110;
        e.j = 0; e.pc = 32'h304;
        step("bltu_not_taken");

        func3 = 3'b101;
        step("bge_not_taken");

        func3 = 3'b111;
        e.j = 1; e.pc = 32'h310;
        step("bgeu_taken");

        func3 = 3'b010; rs2_input = 32'hFFFFFFFF;
        e.j = 0; e.pc = 32'h304;
        step("branch_f3_010");

        // rs1 not valid -> treated as zero, so BEQ against zero rs2 is taken
        set_instr(7'b1100011, 3'b000, 32'h400, 11);
        rs1_input = 32'h1234; rs2_valid = 1; imm = 32'h8; imm_valid = 1;
        e.rs2o = 1; e.jmp = 32'h408; e.j = 1; e.pc = 32'h408;
        step("beq_rs1_invalid");

        set_instr(7'b1100111, 3'b000, 32'h40, 20);
        rs1_input = 32'h1001; imm = 4; rs1_valid = 1; imm_valid = 1; rd_valid = 1;
        e.rs1o = 1; e.j = 1; e.jmp = 32'h1004; e.pc = 32'h1004; e.fin = 32'h44;
        step("jalr");

        set_instr(7'b1101111, 3'b000, 32'h500, 21);
        imm = 32'h100; imm_valid = 1; rd_valid = 1;
        e.j = 1; e.jmp = 32'h600; e.pc = 32'h600; e.fin = 32'h504;
        step("jal");

        set_instr(7'b0000011, 3'b000, 32'h80, 30);
        mem_read = 32'h000000F0; rd_valid = 1;
        e.rd = 1; e.ad = 1; e.fin = 32'hFFFFFFF0;
        step("lb");

        func3 = 3'b100;
        e.fin = 32'h000000F0;
        step("lbu");

        func3 = 3'b001; mem_read = 32'h00008001;
        e.fin = 32'hFFFF8001;
        step("lh");

        func3 = 3'b101;
        e.fin = 32'h00008001;
        step("lhu");

        func3 = 3'b010; mem_read = 32'hDEADBEEF;
        e.fin = 32'hDEADBEEF;
        step("lw");

        rd_valid = 0;
        e.fin = 32'h0;
        step("lw_no_rd");

        set_instr(7'b0100011, 3'b001, 32'h90, 35);
        rs2_input = 32'h12345678; rs2_valid = 1;
        e.rs2o = 1; e.wr = 1; e.ad = 1; e.memw = 32'h00005678;
        step("sh");

        func3 = 3'b000;
        e.memw = 32'h00000078;
        step("sb");

        func3 = 3'b010;
        e.memw = 32'h12345678;
        step("sw");

        func3 = 3'b011;
        e.wr = 0; e.ad = 0; e.memw = 32'h0;
        step("store_bad_f3");

        set_instr(7'b0110111, 3'b000, 32'hA0, 1);
        imm = 32'hABCDE000; imm_valid = 1; rd_valid = 1;
        e.fin = 32'hABCDE000;
        step("lui");

        set_instr(7'b0010111, 3'b000, 32'h1000, 2);
        imm = 32'h2000; imm_valid = 1; rd_valid = 1;
        e.fin = 32'h3000;
        step("auipc");

        set_instr(7'b0010011, 3'b000, 32'hB0, 3);
        rd_input = 32'hCAFE0001; rd_valid = 1;
        e.fin = 32'hCAFE0001;
        step("opimm");

        // Decoder bits disagree with opcode -> NOP
        set_instr(7'b0110011, 3'b000, 32'hC0, 6);
        decoder_signal = 32'h00000013; rd_input = 32'h77; rd_valid = 1;
        e.instr = '0;
        step("illegal_mismatch");

        set_instr(7'b0110011, 3'b000, 32'hD0, 6);
        func7 = 7'h01; rd_input = 32'h77; rd_valid = 1;
        e.instr = '0;
        step("illegal_func7");

        set_instr(7'b0110011, 3'b000, 32'hE0, 7);
        func7 = 7'h20; rd_input = 32'h99; rd_valid = 1;
        e.fin = 32'h99;
        step("op_sub_func7");

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
